riscv_wb_arbiter: RTL
=====================

# riscv_wb_arbiter

Writeback arbiter sitting directly upstream of the integer/FP register file. It collects results from the EX stage, the LSU load response and the multicycle units (mul/div/FPU), and maps them onto the register file's two write ports (A and B), each with its DIFT tag. Multicycle results are held in a small FIFO so that they never stall EX or LSU. All write-port outputs are registered.

## Interface
- ADDR_WIDTH, 6: register address width; bit 5 selects the FP bank, 0x00 is x0.
- DATA_WIDTH, 32: result width.
- TAG_WIDTH, 4: DIFT tag width carried alongside each result.
- MC_DEPTH, 2: multicycle FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  EX result valid; always accepted, no ready
- ex_waddr_i / ex_wdata_i / ex_wtag_i  in  ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH  EX destination, data, tag
- lsu_valid_i  in  1  load result valid; always accepted
- lsu_waddr_i / lsu_wdata_i / lsu_wtag_i  in  ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH  load destination, data, tag
- mc_valid_i  in  1  multicycle result valid
- mc_ready_o  out  1  FIFO not full
- mc_waddr_i / mc_wdata_i / mc_wtag_i  in  ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH  multicycle destination, data, tag
- we_a_o, waddr_a_o, wdata_a_o, wtag_a_o  out  1 / ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH  register file write port A
- we_b_o, waddr_b_o, wdata_b_o, wtag_b_o  out  1 / ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH  register file write port B
- mc_count_o  out  $clog2(MC_DEPTH)+1  FIFO occupancy

## Operation
- Reset values: all port A/B outputs are 0, mc_count_o is 0, mc_ready_o is 1.
- MC FIFO:
  - Circular buffer with read/write pointers that wrap modulo MC_DEPTH.
  - Push when mc_valid_i && mc_ready_o.
  - mc_ready_o = (count != MC_DEPTH). It is combinational from the count only, with no dependence on mc_valid_i.
- Per-cycle port assignment (combinational select, registered outputs):
  - Port A source: EX if ex_valid_i; else the FIFO head if the FIFO is non-empty and port B is taken by LSU; else idle.
  - Port B source: LSU if lsu_valid_i; else the FIFO head if non-empty; else idle.
  - At most one FIFO pop per cycle. The FIFO head is never issued on both ports.
- Pop and push in the same cycle: the count is unchanged. A push into an empty FIFO does not pass through in the same cycle; it can issue the next cycle at the earliest.
- FIFO full with a pop this cycle: mc_ready_o stays 0 this cycle, because readiness is count-based.
- Destination 0x00 (x0): the selected source is consumed (a FIFO entry is popped), but its we output is forced to 0. Address 0x20 (f0) is a normal write.
- Same-address collision on A and B in one cycle: both we outputs are asserted. The register file's B-over-A priority decides the winner. The producers order their instructions so the older result goes to A.
- Idle port: we is 0. waddr/wdata/wtag hold their last values; they are not cleared.
- Reset asserted mid-operation: FIFO contents are discarded, pointers and count return to 0, and all outputs go to their reset values immediately (asynchronously).

## Timing
- Source valid in cycle N → we_x_o high in cycle N+1 → register readable in cycle N+2.
- MC result pushed in cycle N, FIFO otherwise empty, port B free in N+1 → we_b_o high in N+2.
- Throughput: up to 2 writes per cycle. The FIFO drains at 1 entry per cycle.
- No combinational path from any *_valid_i to any output, except mc_valid_i → nothing (mc_ready_o does not depend on it).

## Test plan
- Reset, then EX valid with addr 5, data 0xDEADBEEF, tag 0x3 → next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF, wtag_a_o=0x3; we_b_o=0.
- MC push of addr 0x21, data 0x1 while EX and LSU are idle → we_b_o=1 with addr 0x21 two cycles later; mc_count_o goes 1 then 0.
- Three MC pushes on back-to-back cycles while LSU is valid every cycle and EX is busy → mc_ready_o=0 at count 2, third push not accepted; once EX goes idle, entries drain on port A in FIFO order.
- EX and LSU both valid to addr 7 in the same cycle → both we high next cycle, waddr_a_o=waddr_b_o=7.
- MC entry with addr 0 → popped (mc_count_o decrements), we_b_o stays 0.
- rst_n asserted while the FIFO holds 2 entries → mc_count_o=0, mc_ready_o=1, we outputs 0; nothing drains after release.

Source files
------------

// File: rtl/riscv_wb_arbiter_if.sv
// Writeback arbiter bus bundle: EX, LSU and multicycle result producers plus
// the two register file write ports and the multicycle FIFO status.
// master: producer/register-file side; slave: the arbiter itself.
interface riscv_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int MC_DEPTH   = 2
);
  localparam int CNT_WIDTH = $clog2(MC_DEPTH) + 1;

  logic                  ex_valid_i;
  logic [ADDR_WIDTH-1:0] ex_waddr_i;
  logic [DATA_WIDTH-1:0] ex_wdata_i;
  logic [TAG_WIDTH-1:0]  ex_wtag_i;

  logic                  lsu_valid_i;
  logic [ADDR_WIDTH-1:0] lsu_waddr_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;
  logic [TAG_WIDTH-1:0]  lsu_wtag_i;

  logic                  mc_valid_i;
  logic                  mc_ready_o;
  logic [ADDR_WIDTH-1:0] mc_waddr_i;
  logic [DATA_WIDTH-1:0] mc_wdata_i;
  logic [TAG_WIDTH-1:0]  mc_wtag_i;

  logic                  we_a_o;
  logic [ADDR_WIDTH-1:0] waddr_a_o;
  logic [DATA_WIDTH-1:0] wdata_a_o;
  logic [TAG_WIDTH-1:0]  wtag_a_o;

  logic                  we_b_o;
  logic [ADDR_WIDTH-1:0] waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_b_o;
  logic [TAG_WIDTH-1:0]  wtag_b_o;

  logic [CNT_WIDTH-1:0]  mc_count_o;

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i, ex_wtag_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i, lsu_wtag_i,
    output mc_valid_i, mc_waddr_i, mc_wdata_i, mc_wtag_i,
    input  mc_ready_o,
    input  we_a_o, waddr_a_o, wdata_a_o, wtag_a_o,
    input  we_b_o, waddr_b_o, wdata_b_o, wtag_b_o,
    input  mc_count_o
  );

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i, ex_wtag_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i, lsu_wtag_i,
    input  mc_valid_i, mc_waddr_i, mc_wdata_i, mc_wtag_i,
    output mc_ready_o,
    output we_a_o, waddr_a_o, wdata_a_o, wtag_a_o,
    output we_b_o, waddr_b_o, wdata_b_o, wtag_b_o,
    output mc_count_o
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Purpose: map EX, LSU and buffered multicycle results onto register file write ports A/B.
// Latency: source valid in cycle N -> we on port in N+1; MC results issue no earlier than push+2.
// Backpressure: EX/LSU always accepted; MC stalls only via mc_ready_o (FIFO count != MC_DEPTH).
// Ports: clk, rst_n (async active-low), bus (slave modport: EX/LSU/MC result inputs,
//        mc_ready_o, registered write ports A and B with DIFT tags, mc_count_o).
module riscv_wb_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int MC_DEPTH   = 2
) (
  input  logic clk,
  input  logic rst_n,
  riscv_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(MC_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } wb_t;

  wb_t              mem [MC_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  wb_t  head;
  logic fifo_nempty;
  logic mc_ready;
  logic push, pop;
  logic a_from_mc, b_from_mc;

  assign head        = mem[rd_ptr];
  assign fifo_nempty = (count != '0);
  // Readiness is derived from the registered count only, so a full FIFO that
  // pops this cycle still refuses the push.
  assign mc_ready    = (count != CNT_W'(MC_DEPTH));
  assign push        = bus.mc_valid_i && mc_ready;

  // The head only goes to A when LSU owns B; the two conditions are mutually
  // exclusive on lsu_valid_i, so the head can never issue twice.
  assign a_from_mc = !bus.ex_valid_i && bus.lsu_valid_i && fifo_nempty;
  assign b_from_mc = !bus.lsu_valid_i && fifo_nempty;
  assign pop       = a_from_mc || b_from_mc;

  assign bus.mc_ready_o = mc_ready;
  assign bus.mc_count_o = count;

  // Storage needs no reset: entries are only observed through count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: bus.mc_waddr_i, data: bus.mc_wdata_i, tag: bus.mc_wtag_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Port A. Writes to x0 are consumed but never enabled; idle keeps fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.we_a_o    <= 1'b0;
      bus.waddr_a_o <= '0;
      bus.wdata_a_o <= '0;
      bus.wtag_a_o  <= '0;
    end else if (bus.ex_valid_i) begin
      bus.we_a_o    <= (bus.ex_waddr_i != '0);
      bus.waddr_a_o <= bus.ex_waddr_i;
      bus.wdata_a_o <= bus.ex_wdata_i;
      bus.wtag_a_o  <= bus.ex_wtag_i;
    end else if (a_from_mc) begin
      bus.we_a_o    <= (head.addr != '0);
      bus.waddr_a_o <= head.addr;
      bus.wdata_a_o <= head.data;
      bus.wtag_a_o  <= head.tag;
    end else begin
      bus.we_a_o    <= 1'b0;
    end
  end

  // Port B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.we_b_o    <= 1'b0;
      bus.waddr_b_o <= '0;
      bus.wdata_b_o <= '0;
      bus.wtag_b_o  <= '0;
    end else if (bus.lsu_valid_i) begin
      bus.we_b_o    <= (bus.lsu_waddr_i != '0);
      bus.waddr_b_o <= bus.lsu_waddr_i;
      bus.wdata_b_o <= bus.lsu_wdata_i;
      bus.wtag_b_o  <= bus.lsu_wtag_i;
    end else if (b_from_mc) begin
      bus.we_b_o    <= (head.addr != '0);
      bus.waddr_b_o <= head.addr;
      bus.wdata_b_o <= head.data;
      bus.wtag_b_o  <= head.tag;
    end else begin
      bus.we_b_o    <= 1'b0;
    end
  end
endmodule
